// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_pkg
//  Description : Shared types and helpers for the rc4 feeder stage: byte
//                width, feeder state encoding and the key-length clamp.
//  Revision    : 1.0 - initial release
// ============================================================================
package rc4_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    KEY_STREAM = 2'd1,
    PT_STREAM  = 2'd2
  } feeder_state_e;

  // A zero or oversized key length means "use the whole key store".
  function automatic logic [BYTE_W-1:0] clamp_key_len(
    input logic [BYTE_W-1:0] len,
    input logic [BYTE_W-1:0] max_len
  );
    if ((len == '0) || (len > max_len)) return max_len;
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rc4_feeder_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_feeder_fifo
//  Description : Synchronous byte FIFO for host plaintext. Power-of-two
//                depth, registered full flag, no empty bypass.
//  Revision    : 1.0 - initial release
// ============================================================================
module rc4_feeder_fifo
  import rc4_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [BYTE_W-1:0]        data_i,
  input  logic                     pop_i,
  output logic [BYTE_W-1:0]        head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int                c_aw      = $clog2(DEPTH);
  localparam logic [c_aw:0]     c_depth   = DEPTH[c_aw:0];
  localparam logic [c_aw:0]     c_lvl_one = {{c_aw{1'b0}}, 1'b1};
  localparam logic [c_aw-1:0]   c_ptr_one = {{(c_aw-1){1'b0}}, 1'b1};

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [c_aw-1:0]   wr_ptr_q;
  logic [c_aw-1:0]   rd_ptr_q;
  logic [c_aw:0]     level_q;
  logic [c_aw:0]     level_d;
  logic              full_q;
  logic              do_push;
  logic              do_pop;

  // Level only reflects registered occupancy, so a byte written this cycle
  // cannot be popped until the next one.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && (level_q != '0);

  // Next occupancy; simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + c_lvl_one;
      2'b01:   level_d = level_q - c_lvl_one;
      default: level_d = level_q;
    endcase
  end

  // Pointers, occupancy and the registered full flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + c_ptr_one;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + c_ptr_one;
      level_q <= level_d;
      full_q  <= (level_d == c_depth);
    end
  end

  // Storage is not reset; only the pointers define valid content.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (level_q == '0);
  assign full_o  = full_q;
  assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/rc4_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_feeder
//  Description : Source stage for the rc4 core. Holds a host key, buffers
//                host plaintext and streams key then plaintext bytes to the
//                core on its request pulses, raising HOLD when starved.
//                Optional macro RC4_FEEDER_BYTE_CNT_EN adds PT_BYTE_CNT_OUT,
//                a wrapping count of plaintext bytes delivered.
//  Revision    : 1.0 - initial release
// ============================================================================
module rc4_feeder
  import rc4_pkg::*;
#(
  parameter int KEY_MAX    = 32,
  parameter int FIFO_DEPTH = 64,
  parameter int LEN_W      = 16
) (
  input  logic                          CLK_IN,
  input  logic                          RESET_IN,
  input  logic                          KEY_WR_EN_IN,
  input  logic [$clog2(KEY_MAX)-1:0]    KEY_WR_ADDR_IN,
  input  logic [BYTE_W-1:0]             KEY_WR_DATA_IN,
  input  logic [BYTE_W-1:0]             KEY_LEN_IN,
  input  logic [LEN_W-1:0]              MSG_LEN_IN,
  input  logic                          PT_VALID_IN,
  input  logic [BYTE_W-1:0]             PT_DATA_IN,
  output logic                          PT_READY_OUT,
  input  logic                          START_KEY_CPY_IN,
  input  logic                          READ_PLAINTEXT_IN,
  output logic [BYTE_W-1:0]             KEY_SIZE_OUT,
  output logic [BYTE_W-1:0]             KEY_BYTE_OUT,
  output logic [BYTE_W-1:0]             PLAIN_BYTE_OUT,
  output logic                          HOLD_OUT,
  output logic                          BUSY_OUT,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL_OUT
`ifdef RC4_FEEDER_BYTE_CNT_EN
  ,
  output logic [31:0]                   PT_BYTE_CNT_OUT
`endif
);

  localparam int                c_key_aw   = $clog2(KEY_MAX);
  localparam logic [BYTE_W-1:0] c_key_max  = KEY_MAX[BYTE_W-1:0];
  localparam logic [BYTE_W-1:0] c_byte_one = {{(BYTE_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  c_len_one  = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [BYTE_W-1:0] key_mem [KEY_MAX];

  feeder_state_e     state_q, state_d;
  logic [BYTE_W-1:0] key_byte_q, key_byte_d;
  logic [BYTE_W-1:0] plain_byte_q, plain_byte_d;
  logic              hold_q, hold_d;
  logic              busy_q;
  logic [BYTE_W-1:0] key_size_q, key_size_d;
  logic [BYTE_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  msg_len_q, msg_len_d;
  logic              pending_q, pending_d;

  logic              pt_run;
  logic [LEN_W-1:0]  pt_cnt;
  logic [LEN_W-1:0]  pt_len;
  logic              fifo_pop;
  logic              fifo_push;
  logic              fifo_empty;
  logic              fifo_full;
  logic [BYTE_W-1:0] fifo_head;

  assign PT_READY_OUT = !fifo_full;
  assign fifo_push    = PT_VALID_IN && PT_READY_OUT;

  rc4_feeder_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK_IN),
    .rst_i   (RESET_IN),
    .push_i  (fifo_push),
    .data_i  (PT_DATA_IN),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (FIFO_LEVEL_OUT)
  );

  // Key store accepts host writes except while a key stream is reading it.
  always_ff @(posedge CLK_IN) begin
    if (KEY_WR_EN_IN && (state_q != KEY_STREAM)) key_mem[KEY_WR_ADDR_IN] <= KEY_WR_DATA_IN;
  end

  // Stream FSM: next state, output bytes and the plaintext step. A plaintext
  // stream that starts this edge (from IDLE or on key-stream exit) runs its
  // first step immediately with cnt=0 and the freshly sampled length.
  always_comb begin
    state_d      = state_q;
    key_byte_d   = key_byte_q;
    plain_byte_d = plain_byte_q;
    hold_d       = hold_q;
    key_size_d   = key_size_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    msg_len_d    = msg_len_q;
    pending_d    = pending_q;
    pt_run       = 1'b0;
    pt_cnt       = cnt_q;
    pt_len       = msg_len_q;
    fifo_pop     = 1'b0;

    case (state_q)
      IDLE: begin
        if (START_KEY_CPY_IN) begin
          key_byte_d = key_mem[0];
          idx_d      = c_byte_one;
          key_size_d = clamp_key_len(KEY_LEN_IN, c_key_max);
          pending_d  = READ_PLAINTEXT_IN;
          state_d    = KEY_STREAM;
        end else if (READ_PLAINTEXT_IN) begin
          pt_run    = 1'b1;
          pt_cnt    = '0;
          pt_len    = MSG_LEN_IN;
          msg_len_d = MSG_LEN_IN;
        end
      end
      KEY_STREAM: begin
        if (READ_PLAINTEXT_IN) pending_d = 1'b1;
        if (idx_q == key_size_q) begin
          key_byte_d = '0;
          state_d    = IDLE;
          pending_d  = 1'b0;
          if (pending_q || READ_PLAINTEXT_IN) begin
            pt_run    = 1'b1;
            pt_cnt    = '0;
            pt_len    = MSG_LEN_IN;
            msg_len_d = MSG_LEN_IN;
          end
        end else begin
          key_byte_d = key_mem[idx_q[c_key_aw-1:0]];
          idx_d      = idx_q + c_byte_one;
        end
      end
      PT_STREAM: begin
        pt_run = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (pt_run) begin
      if (pt_cnt == pt_len) begin
        plain_byte_d = '0;
        hold_d       = 1'b0;
        state_d      = IDLE;
      end else begin
        state_d = PT_STREAM;
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          plain_byte_d = fifo_head;
          hold_d       = 1'b0;
          cnt_d        = pt_cnt + c_len_one;
        end else begin
          hold_d = 1'b1;
          cnt_d  = pt_cnt;
        end
      end
    end
  end

  // Stream state and output registers.
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      state_q      <= IDLE;
      key_byte_q   <= '0;
      plain_byte_q <= '0;
      hold_q       <= 1'b0;
      busy_q       <= 1'b0;
      key_size_q   <= c_key_max;
      idx_q        <= '0;
      cnt_q        <= '0;
      msg_len_q    <= '0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_byte_q   <= key_byte_d;
      plain_byte_q <= plain_byte_d;
      hold_q       <= hold_d;
      busy_q       <= (state_d != IDLE);
      key_size_q   <= key_size_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      msg_len_q    <= msg_len_d;
      pending_q    <= pending_d;
    end
  end

  assign KEY_SIZE_OUT   = key_size_q;
  assign KEY_BYTE_OUT   = key_byte_q;
  assign PLAIN_BYTE_OUT = plain_byte_q;
  assign HOLD_OUT       = hold_q;
  assign BUSY_OUT       = busy_q;

`ifdef RC4_FEEDER_BYTE_CNT_EN
  logic [31:0] byte_cnt_q;

  // Every FIFO pop is a plaintext byte handed to the core.
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN)      byte_cnt_q <= '0;
    else if (fifo_pop) byte_cnt_q <= byte_cnt_q + 32'd1;
  end

  assign PT_BYTE_CNT_OUT = byte_cnt_q;
`endif

endmodule
`default_nettype wire
